// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read arbiter that connects the
// icache and dcache read-miss ports to one AXI read address/data channel.
package axi_rd_arbiter_pkg;

    localparam logic [2:0] RD_BYTE = 3'b000;
    localparam logic [2:0] RD_HALF = 3'b001;
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } arState_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
    } arReq_t;

    // A line read is aligned down to the line and fetched as a full word
    // burst. Any other read is a single beat whose size follows the
    // access width.
    function automatic arReq_t buildArReq(
        input logic [2:0]  rdType,
        input logic [31:0] addr,
        input logic [3:0]  id,
        input logic [31:0] lineMask,
        input logic [7:0]  lineLen
    );
        arReq_t req;
        req.id = id;
        if (rdType == RD_LINE) begin
            req.addr = addr & lineMask;
            req.len  = lineLen;
            req.size = RD_WORD;
        end else begin
            req.addr = addr;
            req.len  = 8'd0;
            req.size = {1'b0, rdType[1:0]};
        end
        return req;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bundles the two cache read-miss ports and the AXI read channel.
// The "master" modport is the arbiter's view: it is the AXI master and it
// serves the caches. The "slave" modport is the view of the environment,
// meaning the caches and the AXI slave together.
interface axi_rd_arbiter_if;
    import axi_rd_arbiter_pkg::*;

    logic        inst_rd_req;
    logic [2:0]  inst_rd_type;
    logic [31:0] inst_rd_addr;
    logic        inst_rd_rdy;
    logic        inst_ret_valid;
    logic        inst_ret_last;
    logic [31:0] inst_ret_data;

    logic        data_rd_req;
    logic [2:0]  data_rd_type;
    logic [31:0] data_rd_addr;
    logic        data_rd_rdy;
    logic        data_ret_valid;
    logic        data_ret_last;
    logic [31:0] data_ret_data;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_rd_req, inst_rd_type, inst_rd_addr,
        output inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
        input  data_rd_req, data_rd_type, data_rd_addr,
        output data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_rd_req, inst_rd_type, inst_rd_addr,
        input  inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
        output data_rd_req, data_rd_type, data_rd_addr,
        input  data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_rr_grant.sv
// Chooses which cache wins the AR channel. Data wins by default, but inst is
// forced through once data has been granted STARVE_LIMIT times in a row while
// inst sat waiting.
module axi_rd_rr_grant
    import axi_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic inst_out_i,
    input  logic data_out_i,
    input  logic idle_i,
    output logic inst_grant_o,
    output logic data_grant_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starveCnt_q;
    logic [CW-1:0] starveCnt_d;
    logic          instElig;
    logic          dataElig;
    logic          starved;

    // Eligibility and the priority decision, all in the same cycle as the request.
    always_comb begin
        instElig     = inst_req_i & ~inst_out_i & idle_i;
        dataElig     = data_req_i & ~data_out_i & idle_i;
        starved      = (starveCnt_q == CW'(STARVE_LIMIT));
        inst_grant_o = instElig & (~dataElig | starved);
        data_grant_o = dataElig & ~inst_grant_o;
    end

    // Count data wins that pushed a waiting inst aside. Reset the count once inst is served or stops asking.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (inst_grant_o || !inst_req_i) begin
            starveCnt_d = '0;
        end else if (data_grant_o && instElig && !starved) begin
            starveCnt_d = starveCnt_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the icache and dcache. Each cache may
// have one read outstanding, tagged by its own ARID. R beats go back to the
// owning cache according to RID.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS   = 4,
    parameter logic [3:0] INST_ID      = 4'd0,
    parameter logic [3:0] DATA_ID      = 4'd1,
    parameter int         STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    axi_rd_arbiter_if.master   bus,
    output logic               rid_err_o
);

    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

    arState_e arState_q, arState_d;
    arReq_t   arReq_q, arReq_d;
    logic     instOut_q, instOut_d;
    logic     dataOut_q, dataOut_d;
    logic     ridErr_q, ridErr_d;
    logic     instRdy, dataRdy;
    logic     instHit, dataHit;
    logic     instDone, dataDone;
    logic     unusedRresp;

    axi_rd_rr_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .reset        (reset),
        .inst_req_i   (bus.inst_rd_req),
        .data_req_i   (bus.data_rd_req),
        .inst_out_i   (instOut_q),
        .data_out_i   (dataOut_q),
        .idle_i       (arState_q == AR_IDLE),
        .inst_grant_o (instRdy),
        .data_grant_o (dataRdy)
    );

    // The AR stage latches the winner's request when a grant occurs and holds it until the slave accepts it.
    always_comb begin
        arState_d = arState_q;
        arReq_d   = arReq_q;
        unique case (arState_q)
            AR_IDLE: begin
                if (dataRdy) begin
                    arState_d = AR_SEND;
                    arReq_d   = buildArReq(bus.data_rd_type, bus.data_rd_addr, DATA_ID, LINE_MASK, LINE_LEN);
                end else if (instRdy) begin
                    arState_d = AR_SEND;
                    arReq_d   = buildArReq(bus.inst_rd_type, bus.inst_rd_addr, INST_ID, LINE_MASK, LINE_LEN);
                end
            end
            AR_SEND: begin
                if (bus.arready) begin
                    arState_d = AR_IDLE;
                end
            end
            default: arState_d = AR_IDLE;
        endcase
    end

    // Route each R beat by its ID. Track outstanding reads, and flag beats that no read owns.
    always_comb begin
        instHit   = bus.rvalid & (bus.rid == INST_ID) & instOut_q;
        dataHit   = bus.rvalid & (bus.rid == DATA_ID) & dataOut_q;
        instDone  = bus.rvalid & bus.rlast & (bus.rid == INST_ID);
        dataDone  = bus.rvalid & bus.rlast & (bus.rid == DATA_ID);
        instOut_d = (instOut_q & ~instDone) | instRdy;
        dataOut_d = (dataOut_q & ~dataDone) | dataRdy;
        ridErr_d  = ridErr_q | (bus.rvalid & ~instHit & ~dataHit);
    end

    // AR stage, outstanding flags and the sticky ID error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            arState_q <= AR_IDLE;
            arReq_q   <= '0;
            instOut_q <= 1'b0;
            dataOut_q <= 1'b0;
            ridErr_q  <= 1'b0;
        end else begin
            arState_q <= arState_d;
            arReq_q   <= arReq_d;
            instOut_q <= instOut_d;
            dataOut_q <= dataOut_d;
            ridErr_q  <= ridErr_d;
        end
    end

    assign bus.inst_rd_rdy    = instRdy;
    assign bus.data_rd_rdy    = dataRdy;
    assign bus.inst_ret_valid = instHit;
    assign bus.data_ret_valid = dataHit;
    assign bus.inst_ret_last  = bus.rlast;
    assign bus.data_ret_last  = bus.rlast;
    assign bus.inst_ret_data  = bus.rdata;
    assign bus.data_ret_data  = bus.rdata;

    assign bus.arvalid = (arState_q == AR_SEND);
    assign bus.araddr  = arReq_q.addr;
    assign bus.arlen   = arReq_q.len;
    assign bus.arsize  = arReq_q.size;
    assign bus.arid    = arReq_q.id;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.rready  = 1'b1;

    assign rid_err_o   = ridErr_q;
    assign unusedRresp = ^bus.rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter. Inputs change on the
// falling edge, and outputs are sampled 1 time unit later.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ridErr;
    int   checks = 0;
    int   errors = 0;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(
        .LINE_WORDS(4), .INST_ID(4'd0), .DATA_ID(4'd1), .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rid_err_o (ridErr)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        bus.inst_rd_req = 0; bus.inst_rd_type = 0; bus.inst_rd_addr = 0;
        bus.data_rd_req = 0; bus.data_rd_type = 0; bus.data_rd_addr = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_arvalid: got %b expected 0", bus.arvalid); end
        checks++; if ({bus.araddr, bus.arid, bus.arlen, bus.arsize} !== 47'd0) begin errors++; $display("[TB] FAIL rst_arfields: got %h expected 0", {bus.araddr, bus.arid, bus.arlen, bus.arsize}); end
        checks++; if (ridErr !== 1'b0) begin errors++; $display("[TB] FAIL rst_riderr: got %b expected 0", ridErr); end
        checks++; if ({bus.inst_rd_rdy, bus.data_rd_rdy, bus.inst_ret_valid, bus.data_ret_valid} !== 4'b0) begin errors++; $display("[TB] FAIL rst_rdy_ret: got %b expected 0000", {bus.inst_rd_rdy, bus.data_rd_rdy, bus.inst_ret_valid, bus.data_ret_valid}); end
        checks++; if ({bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.rready} !== {2'b01, 2'b00, 4'b0, 3'b0, 1'b1}) begin errors++; $display("[TB] FAIL rst_constants: got %h expected %h", {bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.rready}, {2'b01, 2'b00, 4'b0, 3'b0, 1'b1}); end
        reset = 1'b0;
    endtask

    task automatic test_inst_line();
        @(negedge clk);
        bus.inst_rd_req = 1; bus.inst_rd_type = RD_LINE; bus.inst_rd_addr = 32'h1c000014;
        #1;
        checks++; if ({bus.inst_rd_rdy, bus.data_rd_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL t1_rdy: got %b expected 10", {bus.inst_rd_rdy, bus.data_rd_rdy}); end
        @(negedge clk);
        bus.inst_rd_req = 0;
        #1;
        checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("[TB] FAIL t1_arvalid: got %b expected 1", bus.arvalid); end
        checks++; if (bus.araddr !== 32'h1c000010) begin errors++; $display("[TB] FAIL t1_araddr: got %h expected 1c000010", bus.araddr); end
        checks++; if ({bus.arlen, bus.arsize, bus.arid} !== {8'd3, 3'd2, 4'd0}) begin errors++; $display("[TB] FAIL t1_arlen_size_id: got %h expected %h", {bus.arlen, bus.arsize, bus.arid}, {8'd3, 3'd2, 4'd0}); end
        @(negedge clk);
        bus.arready = 1;
        #1;
        checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("[TB] FAIL t1_arvalid_hold: got %b expected 1", bus.arvalid); end
        @(negedge clk);
        bus.arready = 0; bus.inst_rd_req = 1;
        #1;
        checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("[TB] FAIL t1_arvalid_drop: got %b expected 0", bus.arvalid); end
        checks++; if (bus.inst_rd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL t1_rdy_while_outstanding: got %b expected 0", bus.inst_rd_rdy); end
        @(negedge clk);
        bus.inst_rd_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            bus.rvalid = 1; bus.rid = 4'd0; bus.rdata = 32'hA0000000 + 32'(i); bus.rlast = (i == 3);
            #1;
            checks++; if ({bus.inst_ret_valid, bus.data_ret_valid} !== 2'b10) begin errors++; $display("[TB] FAIL t1_beat%0d_valid: got %b expected 10", i, {bus.inst_ret_valid, bus.data_ret_valid}); end
            checks++; if ({bus.inst_ret_last, bus.inst_ret_data} !== {(i == 3), 32'hA0000000 + 32'(i)}) begin errors++; $display("[TB] FAIL t1_beat%0d_data: got %h expected %h", i, {bus.inst_ret_last, bus.inst_ret_data}, {(i == 3), 32'hA0000000 + 32'(i)}); end
        end
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0;
        #1;
        checks++; if (dut.instOut_q !== 1'b0) begin errors++; $display("[TB] FAIL t1_inst_cleared: got %b expected 0", dut.instOut_q); end
    endtask

    task automatic test_both_same_cycle();
        @(negedge clk);
        bus.inst_rd_req = 1; bus.inst_rd_type = RD_WORD; bus.inst_rd_addr = 32'h1c000100;
        bus.data_rd_req = 1; bus.data_rd_type = RD_WORD; bus.data_rd_addr = 32'h80000004;
        #1;
        checks++; if ({bus.inst_rd_rdy, bus.data_rd_rdy} !== 2'b01) begin errors++; $display("[TB] FAIL t2_first_grant: got %b expected 01", {bus.inst_rd_rdy, bus.data_rd_rdy}); end
        @(negedge clk);
        bus.data_rd_req = 0; bus.arready = 1;
        #1;
        checks++; if ({bus.arvalid, bus.arid, bus.arlen, bus.arsize, bus.araddr} !== {1'b1, 4'd1, 8'd0, 3'd2, 32'h80000004}) begin errors++; $display("[TB] FAIL t2_data_ar: got %h expected %h", {bus.arvalid, bus.arid, bus.arlen, bus.arsize, bus.araddr}, {1'b1, 4'd1, 8'd0, 3'd2, 32'h80000004}); end
        checks++; if (bus.inst_rd_rdy !== 1'b0) begin errors++; $display("[TB] FAIL t2_no_grant_in_send: got %b expected 0", bus.inst_rd_rdy); end
        @(negedge clk);
        bus.arready = 0;
        #1;
        checks++; if ({bus.arvalid, bus.inst_rd_rdy} !== 2'b01) begin errors++; $display("[TB] FAIL t2_second_grant: got %b expected 01", {bus.arvalid, bus.inst_rd_rdy}); end
        @(negedge clk);
        bus.inst_rd_req = 0; bus.arready = 1;
        #1;
        checks++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h1c000100}) begin errors++; $display("[TB] FAIL t2_inst_ar: got %h expected %h", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 4'd0, 32'h1c000100}); end
        @(negedge clk);
        bus.arready = 0; bus.rvalid = 1; bus.rid = 4'd1; bus.rlast = 1; bus.rdata = 32'hDDDD0001;
        #1;
        checks++; if ({bus.inst_ret_valid, bus.data_ret_valid, bus.data_ret_data} !== {2'b01, 32'hDDDD0001}) begin errors++; $display("[TB] FAIL t2_data_ret: got %h expected %h", {bus.inst_ret_valid, bus.data_ret_valid, bus.data_ret_data}, {2'b01, 32'hDDDD0001}); end
        @(negedge clk);
        bus.rid = 4'd0; bus.rdata = 32'h11110002;
        #1;
        checks++; if ({bus.inst_ret_valid, bus.data_ret_valid, bus.inst_ret_data} !== {2'b10, 32'h11110002}) begin errors++; $display("[TB] FAIL t2_inst_ret: got %h expected %h", {bus.inst_ret_valid, bus.data_ret_valid, bus.inst_ret_data}, {2'b10, 32'h11110002}); end
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0;
    endtask

    task automatic test_starvation();
        bus.inst_rd_req = 1; bus.inst_rd_type = RD_WORD; bus.inst_rd_addr = 32'h1c000200;
        bus.data_rd_req = 1; bus.data_rd_type = RD_WORD; bus.data_rd_addr = 32'h80000010;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({bus.inst_rd_rdy, bus.data_rd_rdy} !== 2'b01) begin errors++; $display("[TB] FAIL t3_data_win%0d: got %b expected 01", k, {bus.inst_rd_rdy, bus.data_rd_rdy}); end
            @(negedge clk);
            bus.arready = 1; bus.rvalid = 1; bus.rid = 4'd1; bus.rlast = 1;
            #1;
            checks++; if ({bus.arvalid, bus.arid} !== {1'b1, 4'd1}) begin errors++; $display("[TB] FAIL t3_data_ar%0d: got %h expected %h", k, {bus.arvalid, bus.arid}, {1'b1, 4'd1}); end
            @(negedge clk);
            bus.arready = 0; bus.rvalid = 0; bus.rlast = 0;
        end
        #1;
        checks++; if ({bus.inst_rd_rdy, bus.data_rd_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL t3_inst_forced: got %b expected 10", {bus.inst_rd_rdy, bus.data_rd_rdy}); end
        checks++; if (dut.u_grant.starveCnt_q !== 3'd4) begin errors++; $display("[TB] FAIL t3_starve_sat: got %0d expected 4", dut.u_grant.starveCnt_q); end
        @(negedge clk);
        bus.inst_rd_req = 0; bus.data_rd_req = 0; bus.arready = 1;
        #1;
        checks++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h1c000200}) begin errors++; $display("[TB] FAIL t3_inst_ar: got %h expected %h", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 4'd0, 32'h1c000200}); end
        checks++; if (dut.u_grant.starveCnt_q !== 3'd0) begin errors++; $display("[TB] FAIL t3_starve_clear: got %0d expected 0", dut.u_grant.starveCnt_q); end
        @(negedge clk);
        bus.arready = 0; bus.rvalid = 1; bus.rid = 4'd0; bus.rlast = 1;
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0;
    endtask

    task automatic test_interleave();
        logic [3:0] seqId   [6] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
        logic       seqLast [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       expInst;
        logic       expData;
        @(negedge clk);
        bus.inst_rd_req = 1; bus.inst_rd_type = RD_LINE; bus.inst_rd_addr = 32'h1c000048;
        bus.data_rd_req = 1; bus.data_rd_type = RD_LINE; bus.data_rd_addr = 32'h80000024;
        #1;
        checks++; if (bus.data_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t4_data_grant: got %b expected 1", bus.data_rd_rdy); end
        @(negedge clk);
        bus.data_rd_req = 0; bus.arready = 1;
        #1;
        checks++; if ({bus.arid, bus.arlen, bus.araddr} !== {4'd1, 8'd3, 32'h80000020}) begin errors++; $display("[TB] FAIL t4_data_ar: got %h expected %h", {bus.arid, bus.arlen, bus.araddr}, {4'd1, 8'd3, 32'h80000020}); end
        @(negedge clk);
        bus.arready = 0;
        #1;
        checks++; if (bus.inst_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t4_inst_grant: got %b expected 1", bus.inst_rd_rdy); end
        @(negedge clk);
        bus.inst_rd_req = 0; bus.arready = 1;
        #1;
        checks++; if ({bus.arid, bus.araddr} !== {4'd0, 32'h1c000040}) begin errors++; $display("[TB] FAIL t4_inst_ar: got %h expected %h", {bus.arid, bus.araddr}, {4'd0, 32'h1c000040}); end
        @(negedge clk);
        bus.arready = 0;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            bus.rvalid = 1; bus.rid = seqId[j]; bus.rlast = seqLast[j]; bus.rdata = 32'hB0000000 + 32'(j);
            expInst = (seqId[j] == 4'd0);
            expData = (seqId[j] == 4'd1);
            #1;
            checks++; if ({bus.inst_ret_valid, bus.data_ret_valid} !== {expInst, expData}) begin errors++; $display("[TB] FAIL t4_beat%0d_route: got %b expected %b", j, {bus.inst_ret_valid, bus.data_ret_valid}, {expInst, expData}); end
            checks++; if ({bus.inst_ret_last, bus.data_ret_data} !== {seqLast[j], 32'hB0000000 + 32'(j)}) begin errors++; $display("[TB] FAIL t4_beat%0d_data: got %h expected %h", j, {bus.inst_ret_last, bus.data_ret_data}, {seqLast[j], 32'hB0000000 + 32'(j)}); end
        end
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0;
        #1;
        checks++; if ({dut.instOut_q, dut.dataOut_q, ridErr} !== 3'b000) begin errors++; $display("[TB] FAIL t4_flags_cleared: got %b expected 000", {dut.instOut_q, dut.dataOut_q, ridErr}); end
    endtask

    task automatic test_stray_rid();
        @(negedge clk);
        bus.rvalid = 1; bus.rid = 4'd3; bus.rlast = 1; bus.rdata = 32'hEEEEEEEE;
        #1;
        checks++; if ({bus.inst_ret_valid, bus.data_ret_valid, bus.rready} !== 3'b001) begin errors++; $display("[TB] FAIL t5_no_route: got %b expected 001", {bus.inst_ret_valid, bus.data_ret_valid, bus.rready}); end
        @(negedge clk);
        bus.rvalid = 0; bus.rlast = 0; bus.rid = 4'd0;
        #1;
        checks++; if (ridErr !== 1'b1) begin errors++; $display("[TB] FAIL t5_riderr_set: got %b expected 1", ridErr); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ridErr !== 1'b1) begin errors++; $display("[TB] FAIL t5_riderr_sticky: got %b expected 1", ridErr); end
    endtask

    task automatic test_reset_midburst();
        @(negedge clk);
        bus.inst_rd_req = 1; bus.inst_rd_type = RD_WORD; bus.inst_rd_addr = 32'h1c000300;
        bus.data_rd_req = 1; bus.data_rd_type = RD_LINE; bus.data_rd_addr = 32'h80000044;
        #1;
        checks++; if (bus.data_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t6_pre_grant: got %b expected 1", bus.data_rd_rdy); end
        @(negedge clk);
        bus.inst_rd_req = 0; bus.data_rd_req = 0;
        #1;
        checks++; if ({bus.arvalid, dut.dataOut_q, dut.u_grant.starveCnt_q} !== {1'b1, 1'b1, 3'd1}) begin errors++; $display("[TB] FAIL t6_pre_state: got %h expected %h", {bus.arvalid, dut.dataOut_q, dut.u_grant.starveCnt_q}, {1'b1, 1'b1, 3'd1}); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({bus.arvalid, dut.dataOut_q, dut.instOut_q, ridErr} !== 4'b0000) begin errors++; $display("[TB] FAIL t6_post_reset: got %b expected 0000", {bus.arvalid, dut.dataOut_q, dut.instOut_q, ridErr}); end
        checks++; if (dut.u_grant.starveCnt_q !== 3'd0) begin errors++; $display("[TB] FAIL t6_starve_reset: got %0d expected 0", dut.u_grant.starveCnt_q); end
        reset = 1'b0;
        @(negedge clk);
        bus.data_rd_req = 1;
        #1;
        checks++; if (bus.data_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t6_data_rdy: got %b expected 1", bus.data_rd_rdy); end
        @(negedge clk);
        bus.data_rd_req = 0; bus.arready = 1;
        @(negedge clk);
        bus.arready = 0; bus.inst_rd_req = 1;
        #1;
        checks++; if (bus.inst_rd_rdy !== 1'b1) begin errors++; $display("[TB] FAIL t6_inst_rdy: got %b expected 1", bus.inst_rd_rdy); end
        @(negedge clk);
        bus.inst_rd_req = 0; bus.arready = 1;
        @(negedge clk);
        bus.arready = 0;
    endtask

    // Run the scenarios in sequence and report.
    initial begin
        $display("[TB] starting axi_rd_arbiter bench");
        test_reset();
        test_inst_line();
        test_both_same_cycle();
        test_starvation();
        test_interleave();
        test_stray_rid();
        test_reset_midburst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
